// File: rtl/ul8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : ul8_pkg                                                |
// | Description : Shared types and constants for the UL8 program loader  |
// |               and the UL8 CPU (state encoding, RAM geometry, fill    |
// |               value, instruction field widths).                      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package ul8_pkg;

  // Program RAM geometry defaults
  localparam int c_DEPTH  = 32;
  localparam int c_ADDR_W = 5;

  // Value written to unused program words after a short program
  localparam logic [7:0] c_FILL_BYTE = 8'h00;

  // Instruction word split: 3-bit opcode, 5-bit operand
  localparam int c_OPCODE_W  = 3;
  localparam int c_OPERAND_W = 5;

  // Loader state encoding
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FILL  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } ldr_state_t;

endpackage : ul8_pkg
`default_nettype wire

// File: rtl/ul8_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ul8_prog_loader                                        |
// | Description : Streams a byte-wide program into the external program  |
// |               RAM, zero-fills the unused tail and pulses cpu_start.  |
// |               Optional feature macro: UL8_LOADER_CHECKSUM_EN (the    |
// |               last byte is a mod-256 checksum instead of data).      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module ul8_prog_loader #(
  parameter int DEPTH  = ul8_pkg::c_DEPTH,
  parameter int ADDR_W = ul8_pkg::c_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_start,
  output logic              err_overflow,
  output logic              err_checksum
);
  import ul8_pkg::*;

  // Word count at which the RAM is full; the counter is one bit wider than
  // the address so "all DEPTH words written" is representable without wrap.
  localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  ldr_state_t        r_state, w_state_nxt;
  logic [ADDR_W:0]   r_cnt, w_cnt_nxt, w_base_cnt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic [7:0]        r_sum, w_sum_nxt, w_base_sum;
  logic              r_ovf, w_ovf_nxt;
  logic              r_cks, w_cks_nxt;
  logic              w_accept;
  logic              w_is_data;
  logic              w_cks_bad;

  assign in_ready = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign w_accept = in_valid && in_ready;

`ifdef UL8_LOADER_CHECKSUM_EN
  // The in_last byte carries the checksum and is never stored.
  assign w_is_data = ~in_last;
  assign w_cks_bad = (in_data != w_base_sum);
`else
  // Every byte, including the in_last byte, is program data.
  assign w_is_data = 1'b1;
  assign w_cks_bad = 1'b0;
`endif

  // A new program always starts at address 0 with an empty checksum.
  assign w_base_cnt = (r_state == S_IDLE) ? '0 : r_cnt;
  assign w_base_sum = (r_state == S_IDLE) ? 8'h00 : r_sum;

  assign busy         = (r_state == S_LOAD) || (r_state == S_FILL) || (r_state == S_DRAIN);
  assign cpu_start    = (r_state == S_DONE) && !r_cks;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign err_overflow = r_ovf;
  assign err_checksum = r_cks;

  // Next-state and next-register values; the write port is registered so
  // a byte accepted in one cycle is presented to the RAM in the next.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_sum_nxt   = r_sum;
    w_ovf_nxt   = r_ovf;
    w_cks_nxt   = r_cks;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          if (r_state == S_IDLE) begin
            w_ovf_nxt = 1'b0;
            w_cks_nxt = 1'b0;
          end
          if (w_is_data && (w_base_cnt == c_DEPTH_CNT)) begin
            // No room left: drop the byte. If it already ends the program
            // there is nothing left to drain.
            w_ovf_nxt   = 1'b1;
            w_state_nxt = in_last ? S_IDLE : S_DRAIN;
          end else if (w_is_data) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = w_base_cnt[ADDR_W-1:0];
            w_wdata_nxt = in_data;
            w_cnt_nxt   = w_base_cnt + 1'b1;
            w_sum_nxt   = w_base_sum + in_data;
            w_state_nxt = in_last ? S_FILL : S_LOAD;
          end else begin
            // Checksum byte: compare only, FILL runs regardless.
            w_cnt_nxt   = w_base_cnt;
            w_cks_nxt   = w_cks_bad;
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (r_cnt < c_DEPTH_CNT) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_cnt[ADDR_W-1:0];
          w_wdata_nxt = c_FILL_BYTE;
          w_cnt_nxt   = r_cnt + 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (w_accept && in_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 8'h00;
      r_sum   <= 8'h00;
      r_ovf   <= 1'b0;
      r_cks   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_sum   <= w_sum_nxt;
      r_ovf   <= w_ovf_nxt;
      r_cks   <= w_cks_nxt;
    end
  end

endmodule : ul8_prog_loader
`default_nettype wire
